// File: rtl/nes_bus_pkg.sv
// Shared definitions for the NES CPU/system bus glue: DMA controller states
// and the default register addresses used by the $4014 OAM DMA.
package nes_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } dma_state_e;

    localparam logic [15:0] DEFAULT_DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] DEFAULT_OAM_DATA_ADDR = 16'h2004;

endpackage

// File: rtl/nes_oam_dma.sv
// Bus controller between the ag6502 core and the NES system bus. Passes CPU
// cycles through, and on a write to the DMA register copies one page to OAM.
module nes_oam_dma
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR  = DEFAULT_DMA_REG_ADDR,
    parameter logic [15:0] OAM_DATA_ADDR = DEFAULT_OAM_DATA_ADDR,
    parameter int unsigned ALIGN_EN      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ph1_rising,
    input  logic        ph2_falling,
    input  logic [15:0] cpu_ab,
    input  logic        cpu_read,
    input  logic [7:0]  cpu_db_out,
    output logic        cpu_rdy,
    output logic [15:0] bus_ab,
    output logic        bus_read,
    output logic [7:0]  bus_db_out,
    input  logic [7:0]  bus_db_in,
    output logic        dma_active
);

    dma_state_e  state_q;
    dma_state_e  state_d;
    logic [7:0]  idx_q;
    logic [7:0]  page_q;
    logic [7:0]  data_q;
    logic        halted_q;
    logic        pending_q;
    logic        cyc_odd_q;
    logic        rdy_q;
    logic        active_q;

    // The state chosen here becomes the owner of the cycle starting at the
    // next ph1_rising. cyc_odd_q==1 before the toggle means the new cycle is even.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (halted_q) begin
                    if (cyc_odd_q || (ALIGN_EN == 0)) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_ALIGN;
                    end
                end
            end
            ST_ALIGN: state_d = ST_READ;
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: begin
                // idx has already wrapped to 0 after the 256th write.
                if (idx_q == 8'h00) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READ;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (ph1_rising) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= 8'h00;
            page_q    <= 8'h00;
            data_q    <= 8'h00;
            halted_q  <= 1'b0;
            pending_q <= 1'b0;
            cyc_odd_q <= 1'b0;
            rdy_q     <= 1'b1;
            active_q  <= 1'b0;
        end else begin
            if (ph1_rising) begin
                cyc_odd_q <= ~cyc_odd_q;
                if (state_q == ST_IDLE) begin
                    pending_q <= 1'b0;
                end
                if ((state_q == ST_HALT) && (state_d != ST_HALT)) begin
                    active_q <= 1'b1;
                    halted_q <= 1'b0;
                end
                if ((state_q == ST_WRITE) && (state_d == ST_IDLE)) begin
                    active_q <= 1'b0;
                end
            end
            if (ph2_falling) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!cpu_read && (cpu_ab == DMA_REG_ADDR)) begin
                            page_q    <= cpu_db_out;
                            pending_q <= 1'b1;
                            rdy_q     <= 1'b0;
                        end
                    end
                    // A CPU write cycle (interrupt push) is not stalled by rdy,
                    // so the DMA only starts after a read cycle is seen.
                    ST_HALT:  halted_q <= cpu_read;
                    ST_READ:  data_q   <= bus_db_in;
                    ST_WRITE: begin
                        idx_q <= idx_q + 8'd1;
                        if (idx_q == 8'hFF) begin
                            rdy_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus_ab     = cpu_ab;
        bus_read   = cpu_read;
        bus_db_out = cpu_db_out;
        case (state_q)
            ST_ALIGN: begin
                bus_read = 1'b1;
            end
            ST_READ: begin
                bus_ab     = {page_q, idx_q};
                bus_read   = 1'b1;
                bus_db_out = data_q;
            end
            ST_WRITE: begin
                bus_ab     = OAM_DATA_ADDR;
                bus_read   = 1'b0;
                bus_db_out = data_q;
            end
            default: ;
        endcase
    end

    assign cpu_rdy    = rdy_q;
    assign dma_active = active_q;

endmodule

// File: tb/tb_nes_oam_dma.sv
// Directed testbench for nes_oam_dma: pass-through, DMA transfer, alignment,
// pushes during halt, ignored accesses, mid-transfer reset and sparse strobes.
module tb_nes_oam_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        ph1_rising;
    logic        ph2_falling;
    logic [15:0] cpu_ab;
    logic        cpu_read;
    logic [7:0]  cpu_db_out;
    logic        cpu_rdy, bus_read, dma_active;
    logic [15:0] bus_ab;
    logic [7:0]  bus_db_out, bus_db_in;
    logic        cpu_rdy_n, bus_read_n, dma_active_n;
    logic [15:0] bus_ab_n;
    logic [7:0]  bus_db_out_n, bus_db_in_n;

    int vectors     = 0;
    int miscompares = 0;
    int cyc_n       = 0;
    int gap         = 0;
    int st0, ac0, st1, ac1;

    logic [15:0] e_ab, l_ab;
    logic        e_rd, l_rd, e_rdy, e_act, l_act, p_rdy, e_rdy_n, e_act_n;
    logic [7:0]  e_db, l_db;

    always #5 clk = ~clk;

    nes_oam_dma dut (
        .clk(clk), .rst(rst), .ph1_rising(ph1_rising), .ph2_falling(ph2_falling),
        .cpu_ab(cpu_ab), .cpu_read(cpu_read), .cpu_db_out(cpu_db_out),
        .cpu_rdy(cpu_rdy), .bus_ab(bus_ab), .bus_read(bus_read),
        .bus_db_out(bus_db_out), .bus_db_in(bus_db_in), .dma_active(dma_active)
    );

    nes_oam_dma #(.ALIGN_EN(0)) dut_noalign (
        .clk(clk), .rst(rst), .ph1_rising(ph1_rising), .ph2_falling(ph2_falling),
        .cpu_ab(cpu_ab), .cpu_read(cpu_read), .cpu_db_out(cpu_db_out),
        .cpu_rdy(cpu_rdy_n), .bus_ab(bus_ab_n), .bus_read(bus_read_n),
        .bus_db_out(bus_db_out_n), .bus_db_in(bus_db_in_n), .dma_active(dma_active_n)
    );

    // Memory contents are a fixed scramble of the address.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        logic [7:0] hi;
        hi = a[15:8];
        return a[7:0] ^ {hi[3:0], hi[7:4]} ^ 8'h3C;
    endfunction

    assign bus_db_in   = mem_byte(bus_ab);
    assign bus_db_in_n = mem_byte(bus_ab_n);

    task automatic cycle_ph1(input logic [15:0] ab, input logic rd, input logic [7:0] d);
        cpu_ab     = ab;
        cpu_read   = rd;
        cpu_db_out = d;
        ph1_rising = 1'b1;
        @(negedge clk);
        ph1_rising = 1'b0;
        cyc_n++;
        e_ab = bus_ab; e_rd = bus_read; e_db = bus_db_out;
        e_rdy = cpu_rdy; e_act = dma_active;
        e_rdy_n = cpu_rdy_n; e_act_n = dma_active_n;
        st0 += (e_rdy === 1'b0) ? 1 : 0;
        ac0 += (e_act === 1'b1) ? 1 : 0;
        st1 += (e_rdy_n === 1'b0) ? 1 : 0;
        ac1 += (e_act_n === 1'b1) ? 1 : 0;
        repeat (gap) @(negedge clk);
        l_ab = bus_ab; l_rd = bus_read; l_db = bus_db_out; l_act = dma_active;
    endtask

    task automatic cycle_ph2(input logic do_ph2);
        ph2_falling = do_ph2;
        @(negedge clk);
        ph2_falling = 1'b0;
        p_rdy = cpu_rdy;
        repeat (gap) @(negedge clk);
    endtask

    task automatic cpu_cycle(input logic [15:0] ab, input logic rd, input logic [7:0] d,
                             input logic do_ph2);
        cycle_ph1(ab, rd, d);
        cycle_ph2(do_ph2);
    endtask

    task automatic applyStimulus_align_to(input int want_odd);
        if (((cyc_n + 1) % 2) != want_odd) begin
            cpu_cycle(16'hC000, 1'b1, 8'h00, 1'b1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; ph1_rising = 1'b0; ph2_falling = 1'b0;
        cpu_ab = 16'h1234; cpu_read = 1'b0; cpu_db_out = 8'h5A;
        repeat (3) @(negedge clk);
        vectors++;
        if ({cpu_rdy, dma_active, bus_ab, bus_read, bus_db_out, cpu_rdy_n, dma_active_n} !==
            {1'b1, 1'b0, 16'h1234, 1'b0, 8'h5A, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset: got rdy=%b act=%b ab=%h rd=%b db=%h, expected rdy=1 act=0 ab=1234 rd=0 db=5a",
                     cpu_rdy, dma_active, bus_ab, bus_read, bus_db_out);
        end
        rst = 1'b0;
        cyc_n = 0;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        logic [15:0] abs [4] = '{16'h8000, 16'h0300, 16'h4015, 16'hFFFC};
        logic        rds [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0]  dss [4] = '{8'h11, 8'hA5, 8'h00, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            cpu_cycle(abs[i], rds[i], dss[i], 1'b1);
            vectors++;
            if ({e_ab, e_rd, e_db, e_rdy, e_act} !== {abs[i], rds[i], dss[i], 1'b1, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL passthrough[%0d]: got ab=%h rd=%b db=%h rdy=%b act=%b, expected ab=%h rd=%b db=%h rdy=1 act=0",
                         i, e_ab, e_rd, e_db, e_rdy, e_act, abs[i], rds[i], dss[i]);
            end
        end
    endtask

    task automatic test_ignored();
        cpu_cycle(16'h4014, 1'b1, 8'h02, 1'b1);
        cpu_cycle(16'h4015, 1'b0, 8'h02, 1'b1);
        cpu_cycle(16'h4014, 1'b0, 8'h02, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cpu_cycle(16'h0300 + 16'(i), 1'b0, 8'h40 + 8'(i), 1'b1);
            vectors++;
            if ({e_ab, e_rd, e_db, e_rdy, e_act, p_rdy, e_rdy_n} !==
                {16'h0300 + 16'(i), 1'b0, 8'h40 + 8'(i), 1'b1, 1'b0, 1'b1, 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL ignored[%0d]: got ab=%h rd=%b db=%h rdy=%b act=%b post_rdy=%b, expected ab=%h rd=0 db=%h rdy=1 act=0 post_rdy=1",
                         i, e_ab, e_rd, e_db, e_rdy, e_act, p_rdy, 16'h0300 + 16'(i), 8'h40 + 8'(i));
            end
        end
    endtask

    task automatic dma_transfer(input logic [7:0] page, input int n_push, input int exp_align);
        logic [15:0] exp_ab;
        logic [7:0]  exp_db;
        cpu_cycle(16'h4014, 1'b0, page, 1'b1);
        vectors++;
        if ({p_rdy, e_act} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL trigger: got post_rdy=%b act=%b, expected 0 0", p_rdy, e_act);
        end
        st0 = 0; ac0 = 0; st1 = 0; ac1 = 0;
        for (int k = 0; k < n_push; k++) begin
            cpu_cycle(16'h01FD - 16'(k), 1'b0, 8'hA0 + 8'(k), 1'b1);
            vectors++;
            if ({e_ab, e_rd, e_db, e_act, e_rdy} !== {16'h01FD - 16'(k), 1'b0, 8'hA0 + 8'(k), 1'b0, 1'b0}) begin
                miscompares++;
                $display("[TB] FAIL push[%0d]: got ab=%h rd=%b db=%h act=%b rdy=%b, expected ab=%h rd=0 db=%h act=0 rdy=0",
                         k, e_ab, e_rd, e_db, e_act, e_rdy, 16'h01FD - 16'(k), 8'hA0 + 8'(k));
            end
        end
        cpu_cycle(16'hC123, 1'b1, 8'h00, 1'b1);
        vectors++;
        if ({e_ab, e_rd, e_act, e_rdy} !== {16'hC123, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL halt: got ab=%h rd=%b act=%b rdy=%b, expected ab=c123 rd=1 act=0 rdy=0",
                     e_ab, e_rd, e_act, e_rdy);
        end
        if (exp_align != 0) begin
            cpu_cycle(16'hC123, 1'b1, 8'h00, 1'b1);
            vectors++;
            if ({e_ab, e_rd, e_act} !== {16'hC123, 1'b1, 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL align: got ab=%h rd=%b act=%b, expected ab=c123 rd=1 act=1",
                         e_ab, e_rd, e_act);
            end
        end
        for (int i = 0; i < 256; i++) begin
            exp_ab = {page, 8'(i)};
            exp_db = mem_byte(exp_ab);
            cpu_cycle(16'hC123, 1'b1, 8'h00, 1'b1);
            vectors++;
            if ({e_ab, e_rd, e_act} !== {exp_ab, 1'b1, 1'b1} ||
                {l_ab, l_rd, l_act} !== {exp_ab, 1'b1, 1'b1} || (cyc_n % 2) != 0) begin
                miscompares++;
                $display("[TB] FAIL read[%0d]: got ab=%h/%h rd=%b act=%b cycle=%0d, expected ab=%h rd=1 act=1 even cycle",
                         i, e_ab, l_ab, e_rd, e_act, cyc_n, exp_ab);
            end
            cpu_cycle(16'hC123, 1'b1, 8'h00, 1'b1);
            vectors++;
            if ({e_ab, e_rd, e_db, e_act} !== {16'h2004, 1'b0, exp_db, 1'b1} ||
                {l_ab, l_rd, l_db, l_act} !== {16'h2004, 1'b0, exp_db, 1'b1}) begin
                miscompares++;
                $display("[TB] FAIL write[%0d]: got ab=%h rd=%b db=%h/%h act=%b, expected ab=2004 rd=0 db=%h act=1",
                         i, e_ab, e_rd, e_db, l_db, e_act, exp_db);
            end
            if (i == 255) begin
                vectors++;
                if (p_rdy !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL rdy_release: got %b, expected 1", p_rdy);
                end
            end
        end
        cpu_cycle(16'hC123, 1'b1, 8'h00, 1'b1);
        vectors++;
        if ({e_ab, e_rd, e_act, e_rdy} !== {16'hC123, 1'b1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL done: got ab=%h rd=%b act=%b rdy=%b, expected ab=c123 rd=1 act=0 rdy=1",
                     e_ab, e_rd, e_act, e_rdy);
        end
        vectors++;
        if (st0 != 513 + n_push + exp_align || ac0 != 512 + exp_align) begin
            miscompares++;
            $display("[TB] FAIL stall: got stall=%0d active=%0d, expected stall=%0d active=%0d",
                     st0, ac0, 513 + n_push + exp_align, 512 + exp_align);
        end
        vectors++;
        if (st1 != 513 + n_push || ac1 != 512) begin
            miscompares++;
            $display("[TB] FAIL stall_noalign: got stall=%0d active=%0d, expected stall=%0d active=512",
                     st1, ac1, 513 + n_push);
        end
    endtask

    task automatic test_basic_dma();
        applyStimulus_align_to(1);
        dma_transfer(8'h02, 0, 1);
    endtask

    task automatic test_parity();
        applyStimulus_align_to(0);
        dma_transfer(8'h03, 0, 0);
    endtask

    task automatic test_write_during_halt();
        applyStimulus_align_to(0);
        dma_transfer(8'h04, 2, 0);
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        applyStimulus_align_to(1);
        cpu_cycle(16'h4014, 1'b0, 8'h06, 1'b1);
        for (int n = 0; n < 400; n++) begin
            cycle_ph1(16'hC123, 1'b1, 8'h00);
            if (e_ab === 16'h0640 && e_rd === 1'b1) begin
                found = 1;
                break;
            end
            cycle_ph2(1'b1);
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_reach: READ of 0640 not seen within 400 cycles");
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({cpu_rdy, dma_active, bus_ab, bus_read, cpu_rdy_n, dma_active_n} !==
            {1'b1, 1'b0, 16'hC123, 1'b1, 1'b1, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_mid: got rdy=%b act=%b ab=%h rd=%b, expected rdy=1 act=0 ab=c123 rd=1",
                     cpu_rdy, dma_active, bus_ab, bus_read);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc_n = 0;
        dma_transfer(8'h07, 0, 1);
    endtask

    task automatic test_strobe_gaps();
        gap = 5;
        applyStimulus_align_to(1);
        dma_transfer(8'h02, 0, 1);
        gap = 0;
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_passthrough();
        test_ignored();
        test_basic_dma();
        test_parity();
        test_write_during_halt();
        test_reset_mid();
        test_strobe_gaps();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
